// File: rtl/axis_trigger_source_if.sv
// AXI-Stream bundle carried between the trigger source and its downstream sink.
// The master drives data/valid/last and the slave answers with ready.
interface axis_trigger_source_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic [AXIS_TDATA_WIDTH-1:0] tdata;
    logic                        tvalid;
    logic                        tready;
    logic                        tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_trigger_source.sv
// Trigger-driven AXI-Stream word replayer.
// A rising edge on trig_flag captures a data word and a beat count. The word is
// then sent that many times on the stream, with tlast on the final beat. Edges
// that arrive while a burst is in flight are dropped rather than queued.
module axis_trigger_source #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        trig_flag,
    input  logic [AXIS_TDATA_WIDTH-1:0] data,
    input  logic [CNTR_WIDTH-1:0]       cfg_count,
    axis_trigger_source_if.master       m_axis,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);
    localparam logic [CNTR_WIDTH-1:0] CNT_TWO = CNTR_WIDTH'(2);

    state_t                      r_state;
    logic                        r_trig_q;
    logic [AXIS_TDATA_WIDTH-1:0] r_data;
    logic [CNTR_WIDTH-1:0]       r_cnt;
    logic                        r_tvalid;
    logic                        r_tlast;
    logic                        r_busy;
    logic                        r_done;

    logic w_trig_edge;
    logic w_cfg_nonzero;
    logic w_accept;
    logic w_handshake;
    logic w_last_beat;

    // A trigger is accepted only outside SEND and only when it asks for at
    // least one beat; a zero-length request leaves the block where it was.
    assign w_trig_edge   = trig_flag & ~r_trig_q;
    assign w_cfg_nonzero = |cfg_count;
    assign w_accept      = w_trig_edge & w_cfg_nonzero & (r_state != ST_SEND);
    assign w_handshake   = r_tvalid & m_axis.tready;
    assign w_last_beat   = (r_cnt == CNT_ONE);

    // Stream outputs come straight from flops, so tready never reaches tvalid
    // or tdata combinationally and a stalled beat is held unchanged.
    assign m_axis.tdata  = r_data;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;

    // Control FSM with edge detector, beat counter and registered outputs.
    // Reset is asynchronous so an in-flight burst is cut off immediately.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state  <= ST_IDLE;
            r_trig_q <= 1'b0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_trig_q <= trig_flag;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state  <= ST_SEND;
                        r_data   <= data;
                        r_cnt    <= cfg_count;
                        r_tvalid <= 1'b1;
                        r_tlast  <= (cfg_count == CNT_ONE);
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_handshake) begin
                        r_cnt <= r_cnt - CNT_ONE;
                        if (w_last_beat) begin
                            // Exit on cnt==1 so the counter never wraps,
                            // even for the largest programmable count.
                            r_state  <= ST_DONE;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            // The next beat is the last one when two remain now.
                            r_tlast <= (r_cnt == CNT_TWO);
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_trigger_source.sv
// Scoreboard bench for axis_trigger_source: a reference model turns accepted
// triggers into a queue of expected beats; a monitor pops and compares them
// whenever the DUT completes a handshake.
module tb_axis_trigger_source;

    localparam int W = 32;
    localparam int C = 16;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         trig_flag = 1'b0;
    logic [W-1:0] data = '0;
    logic [C-1:0] cfg_count = '0;
    logic         busy;
    logic         done;

    axis_trigger_source_if #(.AXIS_TDATA_WIDTH(W)) bus ();

    axis_trigger_source #(
        .AXIS_TDATA_WIDTH(W),
        .CNTR_WIDTH(C)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .trig_flag (trig_flag),
        .data      (data),
        .cfg_count (cfg_count),
        .m_axis    (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned m_left = 0;
    bit          m_done = 1'b0;
    bit          m_trig_prev = 1'b0;
    int          bursts = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is a list of beats; while beats remain, every
    // cycle with tready consumes one, and new triggers are ignored.
    always @(posedge aclk or posedge areset) begin : model_p
        bit   e;
        beat_t b;
        if (areset) begin
            m_left      = 0;
            m_done      = 1'b0;
            m_trig_prev = 1'b0;
            exp_q.delete();
        end else begin
            e           = trig_flag && !m_trig_prev;
            m_trig_prev = trig_flag;
            if (m_left != 0) begin
                if (bus.tready) begin
                    m_left--;
                    if (m_left == 0) m_done = 1'b1;
                end
            end else if (e && cfg_count != 0) begin
                bursts++;
                $display("burst %0d: %0d beats of %08h", bursts, cfg_count, data);
                m_left = cfg_count;
                m_done = 1'b0;
                for (int i = 0; i < int'(cfg_count); i++) begin
                    b.d    = data;
                    b.last = (i == int'(cfg_count) - 1);
                    exp_q.push_back(b);
                end
            end
        end
    end

    // Monitor: status flags every cycle, beat contents whenever tvalid is up
    // (which also covers stability during stalls), pop on handshake.
    always @(negedge aclk) begin
        chk("tvalid", bus.tvalid, 64'(m_left != 0));
        chk("busy", busy, 64'(m_left != 0));
        chk("done", done, 64'(m_done));
        if (bus.tvalid) begin
            chk("exp_avail", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("tdata", bus.tdata, exp_q[0].d);
                chk("tlast", bus.tlast, exp_q[0].last);
                if (bus.tready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic pulse();
        trig_flag = 1'b1;
        step(1);
        trig_flag = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy && k < limit) begin
            step(1);
            k++;
        end
        chk("burst_timeout", busy, 0);
    endtask

    initial begin
        bit pat [6] = '{1, 0, 0, 1, 0, 1};
        bus.tready = 1'b1;
        data       = 32'hA5A5A5A5;
        cfg_count  = 16'd4;
        step(3);
        areset = 1'b0;
        step(2);

        // Basic 4-beat burst with tready held high.
        pulse();
        wait_idle(20);
        step(2);

        // Stalls: 3 beats under a fixed tready pattern.
        cfg_count = 16'd3;
        trig_flag = 1'b1;
        step(1);
        trig_flag = 1'b0;
        foreach (pat[i]) begin
            bus.tready = pat[i];
            step(1);
        end
        bus.tready = 1'b1;
        wait_idle(20);
        step(2);

        // Mid-burst retrigger and data/count change are ignored.
        cfg_count = 16'd5;
        data      = 32'hA5A5A5A5;
        pulse();
        step(1);
        data      = 32'h12345678;
        cfg_count = 16'd2;
        pulse();
        repeat (6) begin
            bus.tready = 1'($urandom_range(0, 1));
            step(1);
        end
        bus.tready = 1'b1;
        wait_idle(40);
        step(2);

        // Zero-count trigger from IDLE, then a single-beat burst.
        areset = 1'b1;
        step(2);
        areset    = 1'b0;
        cfg_count = 16'd0;
        pulse();
        step(4);
        cfg_count = 16'd1;
        data      = 32'h0000_0001;
        pulse();
        wait_idle(10);
        step(2);

        // Asynchronous reset on beat 2 of 5, restart with trig held high.
        cfg_count = 16'd5;
        data      = 32'h0BADF00D;
        trig_flag = 1'b1;
        step(1);
        step(1);
        chk("pre_reset_tvalid", bus.tvalid, 1);
        #2;
        areset = 1'b1;
        #1;
        chk("async_tvalid", bus.tvalid, 0);
        chk("async_busy", busy, 0);
        chk("async_tlast", bus.tlast, 0);
        step(2);
        areset = 1'b0;
        step(1);
        chk("restart_tvalid", bus.tvalid, 1);
        trig_flag = 1'b0;
        wait_idle(20);
        step(2);

        // Retrigger from DONE, then the maximum count.
        cfg_count = 16'd2;
        data      = 32'hDEADBEEF;
        pulse();
        wait_idle(10);
        step(2);
        cfg_count = 16'hFFFF;
        pulse();
        wait_idle(70000);
        step(2);

        // Random traffic.
        repeat (400) begin
            trig_flag  = ($urandom_range(0, 3) == 0);
            data       = $urandom;
            cfg_count  = C'($urandom_range(0, 5));
            bus.tready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        trig_flag  = 1'b0;
        bus.tready = 1'b1;
        wait_idle(50);
        step(2);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
